ehgu_sync_fifo: RTL and testbench

Single-clock parametrised FIFO built around the team's dual-port RAM, generalising the memory-only FIFO wrapper into a complete buffer. It owns pointer management, full/empty and programmable almost-full/almost-empty flags, a fill-level count, error pulses and a synchronous flush. It has two read modes: standard (registered read, 1-cycle latency) and first-word-fall-through (FWFT). It is used wherever a same-clock stream needs elastic buffering between producer and consumer.

---
 rtl/ehgu_fifo_pkg.sv | 24 ++
 rtl/ehgu_sync_fifo_if.sv | 29 ++
 rtl/ehgu_fifo_ptr.sv | 114 +++++++++++
 rtl/ehgu_ram_dual_port.sv | 37 +++
 rtl/ehgu_sync_fifo.sv | 76 +++++++
 tb/tb_ehgu_sync_fifo.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/ehgu_fifo_pkg.sv
// Shared definitions for the ehgu synchronous FIFO: read-mode selectors and
// wrap-bit pointer compares used by the pointer logic and the top level.
package ehgu_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    localparam int PTR_MAX_W = 32;

    // Pointers carry one extra wrap bit above the aw address bits.
    function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wptr,
                                      input logic [PTR_MAX_W-1:0] rptr,
                                      input int                   aw);
        logic [PTR_MAX_W-1:0] low_mask;
        low_mask = (PTR_MAX_W'(1) << aw) - PTR_MAX_W'(1);
        return ((wptr & low_mask) == (rptr & low_mask)) && (wptr[aw] != rptr[aw]);
    endfunction

    function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wptr,
                                       input logic [PTR_MAX_W-1:0] rptr);
        return wptr == rptr;
    endfunction

endpackage

// File: rtl/ehgu_sync_fifo_if.sv
// Producer/consumer bundle of the ehgu synchronous FIFO; the FIFO is the slave.
interface ehgu_sync_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 7
);
    logic              clr;
    logic              wenable;
    logic [WIDTH-1:0]  wdata;
    logic              renable;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic [AWIDTH:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wenable, wdata, renable,
        input  rdata, rvalid, full, empty, afull, aempty, level, overflow, underflow
    );

    modport slave (
        input  clr, wenable, wdata, renable,
        output rdata, rvalid, full, empty, afull, aempty, level, overflow, underflow
    );
endinterface

// File: rtl/ehgu_fifo_ptr.sv
// Pointer, occupancy and flag logic of the ehgu synchronous FIFO, including
// the head-valid bit of the first-word-fall-through output register.
module ehgu_fifo_ptr
    import ehgu_fifo_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int AWIDTH    = $clog2(DEPTH),
    parameter int FWFT      = FIFO_STD,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr_i,
    input  logic            wenable_i,
    input  logic            renable_i,
    output logic            wr_acc_o,
    output logic            ram_rd_o,
    output logic [AWIDTH:0] wptr_o,
    output logic [AWIDTH:0] rptr_o,
    output logic [AWIDTH:0] level_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            afull_o,
    output logic            aempty_o,
    output logic            overflow_o,
    output logic            underflow_o,
    output logic            rvalid_o
);
    localparam int PW = AWIDTH + 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          rvalid_q, rvalid_d, head_q, head_d;
    logic          wr_acc, rd_acc, ram_has, ram_rd;

    // NOTE: every signal gets a value on every path through this block, so no
    // latch is inferred; clr then overrides the counters.
    always_comb begin
        wr_acc   = wenable_i & ~full_q & ~clr_i;
        rd_acc   = renable_i & ~empty_q & ~clr_i;
        ram_has  = ~ptr_empty(PTR_MAX_W'(wptr_q), PTR_MAX_W'(rptr_q));
        // In FWFT mode the RAM is read to refill the head register, not on demand.
        ram_rd   = (FWFT == FIFO_FWFT) ? (ram_has & (~head_q | rd_acc) & ~clr_i) : rd_acc;
        wptr_d   = wptr_q + {{AWIDTH{1'b0}}, wr_acc};
        rptr_d   = rptr_q + {{AWIDTH{1'b0}}, ram_rd};
        level_d  = level_q + {{AWIDTH{1'b0}}, wr_acc} - {{AWIDTH{1'b0}}, rd_acc};
        head_d   = ram_rd | (head_q & ~rd_acc);
        ovf_d    = wenable_i & full_q & ~clr_i;
        unf_d    = renable_i & empty_q & ~clr_i;
        rvalid_d = rd_acc;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            head_d  = 1'b0;
        end
        if (FWFT == FIFO_FWFT) begin
            full_d  = (level_d == PW'(DEPTH));
            empty_d = ~head_d;
        end else begin
            full_d  = ptr_full(PTR_MAX_W'(wptr_d), PTR_MAX_W'(rptr_d), AWIDTH);
            empty_d = ptr_empty(PTR_MAX_W'(wptr_d), PTR_MAX_W'(rptr_d));
        end
        afull_d  = int'(level_d) >= AFULL_TH;
        aempty_d = int'(level_d) <= AEMPTY_TH;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            head_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= rvalid_d;
            head_q   <= head_d;
        end
    end

    assign wr_acc_o    = wr_acc;
    assign ram_rd_o    = ram_rd;
    assign wptr_o      = wptr_q;
    assign rptr_o      = rptr_q;
    assign level_o     = level_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign afull_o     = afull_q;
    assign aempty_o    = aempty_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign rvalid_o    = (FWFT == FIFO_FWFT) ? ~empty_q : rvalid_q;

endmodule

// File: rtl/ehgu_ram_dual_port.sv
// Simple dual-port RAM: synchronous write port, registered read port.
module ehgu_ram_dual_port #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 7
) (
    input  logic              wclk,
    input  logic              rclk,
    input  logic              rstn,
    input  logic              wen_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              ren_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [2**AWIDTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array has no reset so it can map onto a RAM macro;
    // only the read-data register is reset.
    always_ff @(posedge wclk) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (ren_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ehgu_sync_fifo.sv
// Single-clock FIFO: dual-port RAM storage plus pointer/flag control, with a
// standard registered read or a first-word-fall-through head register.
module ehgu_sync_fifo
    import ehgu_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int AWIDTH    = $clog2(DEPTH),
    parameter int FWFT      = FIFO_STD,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    ehgu_sync_fifo_if.slave   fifo
);
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ehgu_sync_fifo: DEPTH must be a power of 2 and at least 4");
    end
    if (AWIDTH != $clog2(DEPTH)) begin : g_bad_awidth
        $error("ehgu_sync_fifo: AWIDTH is derived from DEPTH and must not be overridden");
    end
    if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH) begin : g_bad_threshold
        $error("ehgu_sync_fifo: almost-full/almost-empty threshold out of range");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $error("ehgu_sync_fifo: FWFT must be 0 or 1");
    end

    logic [AWIDTH:0] wptr, rptr;
    logic            wr_acc, ram_rd;

    ehgu_fifo_ptr #(
        .DEPTH     (DEPTH),
        .AWIDTH    (AWIDTH),
        .FWFT      (FWFT),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ptr (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (fifo.clr),
        .wenable_i   (fifo.wenable),
        .renable_i   (fifo.renable),
        .wr_acc_o    (wr_acc),
        .ram_rd_o    (ram_rd),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .level_o     (fifo.level),
        .full_o      (fifo.full),
        .empty_o     (fifo.empty),
        .afull_o     (fifo.afull),
        .aempty_o    (fifo.aempty),
        .overflow_o  (fifo.overflow),
        .underflow_o (fifo.underflow),
        .rvalid_o    (fifo.rvalid)
    );

    // The RAM read register doubles as rdata: it loads on a standard read or an
    // FWFT prefetch and otherwise holds, including across clr.
    ehgu_ram_dual_port #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .wclk    (clk),
        .rclk    (clk),
        .rstn    (rstn),
        .wen_i   (wr_acc),
        .waddr_i (wptr[AWIDTH-1:0]),
        .wdata_i (fifo.wdata),
        .ren_i   (ram_rd),
        .raddr_i (rptr[AWIDTH-1:0]),
        .rdata_o (fifo.rdata)
    );

endmodule

// File: tb/tb_ehgu_sync_fifo.sv
// Bench for ehgu_sync_fifo: a standard and an FWFT instance (DEPTH=8) share
// stimulus and are compared every cycle against queue-based reference models.
module tb_ehgu_sync_fifo;
    import ehgu_fifo_pkg::*;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int AWIDTH    = 3;
    localparam int AFULL_TH  = DEPTH - 4;
    localparam int AEMPTY_TH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ehgu_sync_fifo_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) if_s ();
    ehgu_sync_fifo_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) if_f ();

    ehgu_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(FIFO_STD),
        .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) u_std (.clk(clk), .rstn(rstn), .fifo(if_s));

    ehgu_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(FIFO_FWFT),
        .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) u_fwft (.clk(clk), .rstn(rstn), .fifo(if_f));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: contents as queues; the FWFT model adds a head-visible bit.
    logic [7:0] qs[$];
    logic [7:0] qf[$];
    logic [7:0] s_rdata;
    bit         s_rvalid, s_ovf, s_unf;
    bit         f_head, f_ovf, f_unf;

    task automatic model_reset();
        qs.delete();
        qf.delete();
        s_rdata  = '0;
        s_rvalid = 0;
        s_ovf    = 0;
        s_unf    = 0;
        f_head   = 0;
        f_ovf    = 0;
        f_unf    = 0;
    endtask

    task automatic model_edge(input bit c, input bit we, input logic [7:0] wd, input bit re);
        bit s_full, s_empty, f_full, f_empty;
        int ram_cnt;
        if (c) begin
            qs.delete();
            qf.delete();
            s_rvalid = 0; s_ovf = 0; s_unf = 0;
            f_head   = 0; f_ovf = 0; f_unf = 0;
            return;
        end
        s_full   = (qs.size() == DEPTH);
        s_empty  = (qs.size() == 0);
        s_ovf    = we && s_full;
        s_unf    = re && s_empty;
        s_rvalid = re && !s_empty;
        if (s_rvalid) s_rdata = qs.pop_front();
        if (we && !s_full) qs.push_back(wd);

        f_full  = (qf.size() == DEPTH);
        f_empty = !f_head;
        ram_cnt = qf.size() - (f_head ? 1 : 0);
        f_ovf   = we && f_full;
        f_unf   = re && f_empty;
        if (re && !f_empty) begin
            void'(qf.pop_front());
            f_head = (ram_cnt > 0);
        end else if (!f_head) begin
            f_head = (ram_cnt > 0);
        end
        if (we && !f_full) qf.push_back(wd);
    endtask

    task automatic compare_all();
        check("std_level",     if_s.level,     qs.size());
        check("std_full",      if_s.full,      qs.size() == DEPTH);
        check("std_empty",     if_s.empty,     qs.size() == 0);
        check("std_afull",     if_s.afull,     qs.size() >= AFULL_TH);
        check("std_aempty",    if_s.aempty,    qs.size() <= AEMPTY_TH);
        check("std_overflow",  if_s.overflow,  s_ovf);
        check("std_underflow", if_s.underflow, s_unf);
        check("std_rvalid",    if_s.rvalid,    s_rvalid);
        check("std_rdata",     if_s.rdata,     s_rdata);
        check("fwft_level",     if_f.level,     qf.size());
        check("fwft_full",      if_f.full,      qf.size() == DEPTH);
        check("fwft_empty",     if_f.empty,     !f_head);
        check("fwft_afull",     if_f.afull,     qf.size() >= AFULL_TH);
        check("fwft_aempty",    if_f.aempty,    qf.size() <= AEMPTY_TH);
        check("fwft_overflow",  if_f.overflow,  f_ovf);
        check("fwft_underflow", if_f.underflow, f_unf);
        check("fwft_rvalid",    if_f.rvalid,    f_head);
        if (f_head) check("fwft_rdata", if_f.rdata, qf[0]);
    endtask

    task automatic drive(input bit c, input bit we, input logic [7:0] wd, input bit re);
        if_s.clr = c; if_s.wenable = we; if_s.wdata = wd; if_s.renable = re;
        if_f.clr = c; if_f.wenable = we; if_f.wdata = wd; if_f.renable = re;
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
    task automatic step(input bit c, input bit we, input logic [7:0] wd, input bit re);
        drive(c, we, wd, re);
        @(posedge clk);
        model_edge(c, we, wd, re);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int wp_tab[4] = '{75, 25, 50, 85};

        drive(0, 0, '0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("fwft_rdata_reset", if_f.rdata, 8'h00);
        rstn = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0);
        check("std_full_at_8",  if_s.full,  1);
        check("std_level_at_8", if_s.level, 8);
        check("std_afull_at_8", if_s.afull, 1);
        step(0, 1, 8'h09, 0);
        check("std_ovf_pulse",   if_s.overflow, 1);
        check("std_level_ovf",   if_s.level,    8);
        check("fwft_ovf_pulse",  if_f.overflow, 1);
        step(0, 0, '0, 0);
        check("std_ovf_oneshot", if_s.overflow, 0);

        // Drain in order, then one rejected read.
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, '0, 1);
            check("std_drain_data",  if_s.rdata,  i);
            check("std_drain_valid", if_s.rvalid, 1);
        end
        check("std_empty_drained", if_s.empty, 1);
        step(0, 0, '0, 1);
        check("std_unf_pulse",  if_s.underflow, 1);
        check("std_rdata_hold", if_s.rdata,     8'h08);
        check("fwft_unf_pulse", if_f.underflow, 1);

        // Streaming at level 4 across pointer wrap.
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'(8'h14 + i), 1);
            check("std_stream_level",  if_s.level, 4);
            check("fwft_stream_level", if_f.level, 4);
            check("std_stream_data",   if_s.rdata, 8'(8'h10 + i));
        end
        repeat (6) step(0, 0, '0, 1);

        // FWFT two-edge visibility of a single word.
        step(0, 1, 8'hA5, 0);
        check("fwft_empty_edge1", if_f.empty, 1);
        check("std_empty_edge1",  if_s.empty, 0);
        step(0, 0, '0, 0);
        check("fwft_empty_edge2", if_f.empty, 0);
        check("fwft_head_a5",     if_f.rdata, 8'hA5);
        step(0, 0, '0, 1);
        check("fwft_empty_popped", if_f.empty, 1);
        check("std_read_a5",       if_s.rdata, 8'hA5);

        // Flush with a simultaneous write.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0);
        check("std_level_5",  if_s.level, 5);
        check("fwft_level_5", if_f.level, 5);
        step(1, 1, 8'h99, 0);
        check("std_clr_level",  if_s.level,    0);
        check("std_clr_empty",  if_s.empty,    1);
        check("std_clr_noovf",  if_s.overflow, 0);
        check("fwft_clr_level", if_f.level,    0);
        check("fwft_clr_empty", if_f.empty,    1);
        step(0, 1, 8'h77, 0);
        step(0, 0, '0, 0);
        check("fwft_after_clr", if_f.rdata, 8'h77);
        step(0, 0, '0, 1);
        check("std_after_clr", if_s.rdata, 8'h77);

        // Randomised traffic with varying write pressure and occasional flush.
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 100; n++) begin
                step($urandom_range(0, 63) == 0,
                     $urandom_range(0, 99) < wp_tab[b],
                     8'($urandom),
                     $urandom_range(0, 99) >= wp_tab[b]);
            end
        end

        // Asynchronous reset in the middle of a burst at level 6.
        step(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h60 + i), 0);
        check("std_level_6", if_s.level, 6);
        drive(0, 1, 8'h66, 1);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("fwft_rdata_async_rst", if_f.rdata, 8'h00);
        check("std_level_async_rst",  if_s.level, 0);
        @(negedge clk);
        drive(0, 0, '0, 0);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 1, 8'h3C, 0);
        step(0, 0, '0, 0);
        check("fwft_after_rst", if_f.rdata, 8'h3C);
        step(0, 0, '0, 1);
        check("std_after_rst", if_s.rdata, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
